// File: rtl/cmos_capture_16b.sv
// cmos_capture_16b: packs an 8-bit camera byte stream into framed 16-bit RGB565 pixels
module cmos_capture_16b #(
  parameter int H_PIX      = 640,
  parameter int V_LINE     = 480,
  parameter int SKIP_FRAME = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_din,
  input  logic        en_capture,
  output logic [15:0] dout,
  output logic        dout_vld,
  output logic        dout_sop,
  output logic        dout_eop,
  output logic        frame_err
);
  localparam int CW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int RW = (V_LINE > 1) ? $clog2(V_LINE) : 1;
  localparam int SW = (SKIP_FRAME > 0) ? $clog2(SKIP_FRAME + 1) : 1;
  typedef enum logic [1:0] {IDLE, CAPT, DONE} state_t;
  state_t state, state_nxt;
  logic          vsync_ff, href_ff, phase, line_full;
  logic [SW-1:0] skip_cnt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    hi;
  logic vs_rise, skip_done, start, emit, last_col, last_row, eop_hit, href_fall;
  assign vs_rise   = cmos_vsync & ~vsync_ff;
  assign skip_done = skip_cnt == SW'(SKIP_FRAME);
  assign start     = vs_rise & skip_done & en_capture;
  assign emit      = (state == CAPT) & ~vs_rise & cmos_href & phase & ~line_full;
  assign last_col  = col == CW'(H_PIX - 1);
  assign last_row  = row == RW'(V_LINE - 1);
  assign eop_hit   = emit & last_col & last_row;
  assign href_fall = href_ff & ~cmos_href;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // a vsync edge always re-decides capture; eop parks the block until the next frame
  always_comb begin
    state_nxt = state;
    state_nxt = vs_rise ? (start ? CAPT : IDLE) : (eop_hit ? DONE : state);
  end
  // edge detectors, start-up frame skipping and registered pixel outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_ff  <= 1'b0;
      href_ff   <= 1'b0;
      skip_cnt  <= '0;
      dout      <= '0;
      dout_vld  <= 1'b0;
      dout_sop  <= 1'b0;
      dout_eop  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      vsync_ff  <= cmos_vsync;
      href_ff   <= cmos_href;
      if (vs_rise && !skip_done) skip_cnt <= skip_cnt + 1'b1;
      if (emit) dout <= {hi, cmos_din};
      dout_vld  <= emit;
      dout_sop  <= emit & (col == '0) & (row == '0);
      dout_eop  <= eop_hit;
      frame_err <= (state == CAPT) & vs_rise;
    end
  end
  // byte pairing and col/row tracking; line_full marks a line that already delivered H_PIX pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      line_full <= 1'b0;
      hi        <= '0;
      col       <= '0;
      row       <= '0;
    end else if (vs_rise || state != CAPT) begin
      phase     <= 1'b0;
      line_full <= 1'b0;
      col       <= '0;
      row       <= '0;
    end else if (!cmos_href) begin
      phase <= 1'b0;
      if (href_fall && (col != '0 || line_full)) begin
        col       <= '0;
        line_full <= 1'b0;
        row       <= row + 1'b1;
      end
    end else if (!phase) begin
      hi    <= cmos_din;
      phase <= 1'b1;
    end else begin
      phase <= 1'b0;
      if (!line_full) begin
        if (last_col) line_full <= 1'b1;
        else          col <= col + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cmos_capture_16b.sv
// tb_cmos_capture_16b: directed frames checked against a frame-level pixel model
module tb_cmos_capture_16b;
  localparam int H = 4;
  localparam int V = 2;
  localparam int SKIP = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmos_vsync = 1'b0;
  logic        cmos_href = 1'b0;
  logic [7:0]  cmos_din = '0;
  logic        en_capture = 1'b0;
  logic [15:0] dout;
  logic        dout_vld, dout_sop, dout_eop, frame_err;
  cmos_capture_16b #(.H_PIX(H), .V_LINE(V), .SKIP_FRAME(SKIP)) dut (
    .clk(clk), .rst(rst), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_din(cmos_din), .en_capture(en_capture), .dout(dout), .dout_vld(dout_vld),
    .dout_sop(dout_sop), .dout_eop(dout_eop), .frame_err(frame_err)
  );
  always #5 clk = ~clk;
  typedef struct {int cyc; logic [15:0] d; logic sop; logic eop;} exp_t;
  exp_t exp_q[$];
  int err_q[$];
  logic [15:0] got[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int m_skip = 0;
  int m_row = 0;
  bit m_cap = 0;
  bit m_done = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  exp_t e;
  logic ev, ee;
  always @(negedge clk) if (!rst) begin
    ev = exp_q.size() > 0 && exp_q[0].cyc == cyc;
    chk("dout_vld", {31'b0, dout_vld}, {31'b0, ev});
    if (ev) begin
      e = exp_q.pop_front();
      chk("dout", {16'b0, dout}, {16'b0, e.d});
      chk("dout_sop", {31'b0, dout_sop}, {31'b0, e.sop});
      chk("dout_eop", {31'b0, dout_eop}, {31'b0, e.eop});
      got.push_back(dout);
    end else begin
      chk("sop_idle", {31'b0, dout_sop}, 32'd0);
      chk("eop_idle", {31'b0, dout_eop}, 32'd0);
    end
    ee = err_q.size() > 0 && err_q[0] == cyc;
    if (ee) void'(err_q.pop_front());
    chk("frame_err", {31'b0, frame_err}, {31'b0, ee});
  end
  task automatic vs(input bit en);
    @(negedge clk);
    cmos_vsync = 1'b1;
    en_capture = en;
    if (m_skip < SKIP) m_skip++;
    else begin
      if (m_cap && !m_done) err_q.push_back(cyc + 1);
      m_cap = en;
      m_done = 0;
      m_row = 0;
    end
    repeat (3) @(negedge clk);
    cmos_vsync = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic line(input int n, input logic [7:0] b0);
    logic [7:0] hb;
    int k;
    exp_t x;
    k = 0;
    hb = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmos_href = 1'b1;
      cmos_din = b0 + 8'(i);
      if (i % 2 == 0) hb = cmos_din;
      else begin
        if (m_cap && !m_done && k < H) begin
          x.cyc = cyc + 1;
          x.d = {hb, cmos_din};
          x.sop = (m_row == 0 && k == 0);
          x.eop = (m_row == V - 1 && k == H - 1);
          exp_q.push_back(x);
          if (x.eop) m_done = 1;
        end
        k++;
      end
    end
    @(negedge clk);
    cmos_href = 1'b0;
    cmos_din = '0;
    if (m_cap && !m_done && k > 0) m_row++;
    repeat (2) @(negedge clk);
  endtask
  task automatic frame(input bit en, input logic [7:0] b0);
    vs(en);
    line(8, b0);
    line(8, b0 + 8'd8);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", {16'b0, dout}, 32'd0);
    chk("rst_vld", {31'b0, dout_vld}, 32'd0);
    chk("rst_err", {31'b0, frame_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    frame(1, 8'hA0);
    frame(1, 8'hB0);
    chk("skip_none", got.size(), 0);
    got.delete();
    frame(1, 8'h01);
    chk("first_cnt", got.size(), 8);
    if (got.size() == 8) begin
      chk("first_px0", {16'b0, got[0]}, 32'h0102);
      chk("first_px7", {16'b0, got[7]}, 32'h0F10);
    end
    vs(1);
    line(5, 8'h20);
    line(12, 8'h40);
    vs(1);
    line(12, 8'h50);
    line(8, 8'h60);
    got.delete();
    vs(1);
    line(8, 8'h70);
    line(2, 8'h78);
    chk("err_pre_cnt", got.size(), 5);
    frame(1, 8'h80);
    vs(1);
    line(8, 8'h90);
    en_capture = 1'b0;
    line(8, 8'h98);
    got.delete();
    frame(0, 8'hC0);
    chk("disabled_cnt", got.size(), 0);
    frame(1, 8'hD0);
    vs(1);
    line(6, 8'h31);
    chk("pre_rst_dout", {16'b0, dout}, 32'h3536);
    @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    err_q.delete();
    m_skip = 0;
    m_cap = 0;
    m_done = 0;
    m_row = 0;
    #1;
    chk("arst_dout", {16'b0, dout}, 32'd0);
    chk("arst_vld", {31'b0, dout_vld}, 32'd0);
    chk("arst_eop", {31'b0, dout_eop}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got.delete();
    frame(1, 8'hE0);
    frame(1, 8'hF0);
    chk("reskip_cnt", got.size(), 0);
    frame(1, 8'h61);
    chk("recap_cnt", got.size(), 8);
    if (got.size() > 0) chk("recap_px0", {16'b0, got[0]}, 32'h6162);
    repeat (4) @(negedge clk);
    chk("exp_left", exp_q.size(), 0);
    chk("err_left", err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmos_capture_16b.md
Name: cmos_capture_16b

Overview:
- Upstream neighbour of the 16-to-48 bus converter. It runs in the camera pixel-clock domain.
- It takes the 8-bit camera stream (vsync/href/data) and packs byte pairs into 16-bit RGB565 pixels.
- It frames each picture as one packet: sop on the first pixel, eop on pixel H_PIX*V_LINE.
- It discards start-up frames, gates capture per frame, and flags truncated frames.

Parameters:
- H_PIX, 640, pixels per line.
- V_LINE, 480, lines per frame.
- SKIP_FRAME, 10, number of vsync rising edges ignored after reset, before any capture.

Ports:
- clk  input  1  camera pixel clock (pclk); all logic runs on its rising edge.
- rst  input  1  asynchronous reset, active-high.
- cmos_vsync  input  1  frame sync, active-high; a rising edge marks frame start. Synchronous to clk.
- cmos_href  input  1  line valid, active-high; one byte per clk while high.
- cmos_din  input  8  camera byte; first byte of a pair = pixel[15:8].
- en_capture  input  1  capture enable; sampled only on a vsync rising edge.
- dout  output  16  packed pixel.
- dout_vld  output  1  pixel valid, one-cycle pulse per pixel.
- dout_sop  output  1  first pixel of frame; only when dout_vld=1.
- dout_eop  output  1  last pixel of frame; only when dout_vld=1.
- frame_err  output  1  one-cycle pulse: a captured frame ended before its eop.

Behaviour:
- Reset: all outputs 0. Counters 0, state IDLE, skip count 0, byte phase 0, vsync_ff 0.
- vs_rise = cmos_vsync & ~vsync_ff, where vsync_ff is cmos_vsync registered once.
- Skip counter: increments on each vs_rise until it equals SKIP_FRAME, then saturates. Before saturation, vs_rise causes no state change.
- State machine:
  - IDLE: no output. On vs_rise with skip done and en_capture=1 -> CAPT, clearing col/row/phase.
  - CAPT: packs and emits pixels.
    - On eop emission -> DONE.
    - On vs_rise before eop -> pulse frame_err next cycle and re-evaluate en_capture: if 1, restart CAPT with cleared counters; else -> IDLE.
  - DONE: no output. Waits for vs_rise, then behaves as IDLE does on vs_rise in the same cycle. Back-to-back frames need no gap.
- Byte phase (CAPT only):
  - When cmos_href=1: phase 0 latches cmos_din into hi byte and sets phase 1.
  - When cmos_href=1 and phase=1: forms {hi, cmos_din}, clears phase and advances col.
  - When cmos_href=0: phase is forced to 0; an odd trailing byte is discarded.
- Output timing: dout/dout_vld are registered, 1 cycle after the clk that sampled the second byte.
  - dout_sop=1 when the emitted pixel has col=0 and row=0.
  - dout_eop=1 when it has col=H_PIX-1 and row=V_LINE-1.
  - H_PIX=V_LINE=1 gives sop and eop on the same pixel.
- Counters:
  - col counts 0..H_PIX-1. Pixels beyond H_PIX-1 on the same line are dropped, with no dout_vld.
  - On href falling edge (href_ff=1, href=0): if col>0, col is cleared and row increments.
  - Lines after row V_LINE-1 are unreachable, because eop moves the block to DONE.
- Widths: col is clog2(H_PIX) bits; row is clog2(V_LINE) bits; skip counter is clog2(SKIP_FRAME+1) bits.
- Sampling rules:
  - en_capture changing mid-frame has no effect until the next vs_rise.
  - cmos_vsync high with href high is illegal; data is dropped (not in CAPT, or the frame restarts).
- Reset mid-frame: immediate return to IDLE. The skip count is NOT preserved, so SKIP_FRAME frames are skipped again. No eop is emitted. The downstream converter recovers on the next sop.
- Throughput: at most one pixel every 2 clk. dout_vld is never asserted on consecutive cycles.

Test Plan (H_PIX=4, V_LINE=2, SKIP_FRAME=2 unless noted):
- Reset, then 2 full frames with en_capture=1 -> no dout_vld. A 3rd frame with bytes 0x01..0x10 -> 8 pulses: 0x0102, 0x0304, …, 0x0F10. sop on the 1st pulse, eop on the 8th, each 1 clk after its second byte.
- Capture enabled; line of 5 bytes then href low -> 2 pixels emitted, odd byte dropped. Next line starts at col 0, row 1.
- Line of 12 bytes -> only 4 pixels emitted; row advances once at href fall.
- vs_rise after 5 pixels with en_capture=1 -> frame_err pulse 1 clk later. The next pixel has sop=1, and a full 8-pixel frame follows.
- en_capture deasserted mid-frame -> that frame completes with eop. The next vs_rise with en_capture=0 -> no output for that frame. Re-enable -> the following frame is captured.
- Assert rst after 3 pixels of a captured frame -> outputs 0 immediately, no eop. After release, 2 frames are skipped and the 3rd is captured starting with sop.
